// File: rtl/demux1to2_reg.sv
// 1-to-2 registered demux with one independent holding slot per output.
// Optional delivered-word counters are built when DEMUX_CNT_EN is defined.
module demux1to2_reg #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_sel,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out0_data,
   output logic             out0_valid,
   input  logic             out0_ready,
   output logic [WIDTH-1:0] out1_data,
   output logic             out1_valid,
   input  logic             out1_ready
`ifdef DEMUX_CNT_EN
   ,
   input  logic             cnt_clr,
   output logic [15:0]      cnt0,
   output logic [15:0]      cnt1
`endif
);

   logic rdy0;
   logic rdy1;
   logic acc;
   logic ld0;
   logic ld1;
   logic tx0;
   logic tx1;

   // Readiness only looks at the addressed slot, so a stalled port
   // never blocks words headed for the other one.
   assign rdy0     = ~out0_valid | out0_ready;
   assign rdy1     = ~out1_valid | out1_ready;
   assign in_ready = in_sel ? rdy1 : rdy0;

   assign acc = in_valid & in_ready;
   assign ld0 = acc & ~in_sel;
   assign ld1 = acc & in_sel;
   assign tx0 = out0_valid & out0_ready;
   assign tx1 = out1_valid & out1_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out0_valid <= 1'b0;
         out0_data  <= '0;
      end else if (ld0) begin
         out0_valid <= 1'b1;
         out0_data  <= in_data;
      end else if (tx0) begin
         out0_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out1_valid <= 1'b0;
         out1_data  <= '0;
      end else if (ld1) begin
         out1_valid <= 1'b1;
         out1_data  <= in_data;
      end else if (tx1) begin
         out1_valid <= 1'b0;
      end
   end

`ifdef DEMUX_CNT_EN
   // Clear wins over a same-cycle increment; counts saturate at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt0 <= '0;
         cnt1 <= '0;
      end else if (cnt_clr) begin
         cnt0 <= '0;
         cnt1 <= '0;
      end else begin
         if (tx0 && cnt0 != 16'hFFFF)
            cnt0 <= cnt0 + 16'd1;
         if (tx1 && cnt1 != 16'hFFFF)
            cnt1 <= cnt1 + 16'd1;
      end
   end
`endif

endmodule

// File: doc/demux1to2_reg.md
DEMUX1TO2_REG -- requirements
Module: demux1to2_reg

Interface
REQ-001 Parameter WIDTH, default 32, data width of input and both outputs.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_data  input  WIDTH  word to route.
REQ-005 in_sel  input  1  destination: 0 -> port 0, 1 -> port 1.
REQ-006 in_valid  input  1  in_data/in_sel valid.
REQ-007 in_ready  output  1  block accepts the input word this cycle.
REQ-008 out0_data, out1_data  output  WIDTH  registered output words.
REQ-009 out0_valid, out1_valid  output  1  output slot holds a word.
REQ-010 out0_ready, out1_ready  input  1  downstream accepts the word.
REQ-011 cnt_clr  input  1  synchronous counter clear (DEMUX_CNT_EN only).
REQ-012 cnt0, cnt1  output  16  delivered-word counters (DEMUX_CNT_EN only).

Function
REQ-013 Each output port SHALL own one independent holding register (data + valid).
REQ-014 An input transfer SHALL occur when in_valid & in_ready; an output-j transfer SHALL occur when outj_valid & outj_ready.
REQ-015 in_ready SHALL equal (~outS_valid | outS_ready), where S = in_sel; combinational, no dependence on in_valid.
REQ-016 On an input transfer, in_data SHALL appear on outS_data with outS_valid=1 on the next cycle (latency 1); the other port SHALL be unaffected.
REQ-017 If output j transfers and no new word targets j, outj_valid SHALL clear next cycle.
REQ-018 Simultaneous output-j transfer and input transfer to j SHALL replace the slot with the new word, valid stays 1; sustained throughput 1 word/cycle per port.
REQ-019 While outj_valid=1 and outj_ready=0, outj_data SHALL be held stable.
REQ-020 A stalled port SHALL NOT block input words addressed to the other port (no head-of-line blocking).
REQ-021 outj_data SHALL only load on an input transfer to j; it SHALL retain its last value when valid drops.
REQ-022 in_sel SHALL be ignored when in_valid=0; no state change without an input transfer.

Reset
REQ-023 While rst_n=0: out0_valid=out1_valid=0, out0_data=out1_data=0, cnt0=cnt1=0, regardless of clk.
REQ-024 Reset asserted mid-operation SHALL discard held words; no output transfer is reported after release until a new input transfer.
REQ-025 in_ready SHALL be 1 during and immediately after reset (both slots empty).

Configuration
REQ-026 Macro DEMUX_CNT_EN: when defined, cnt_clr, cnt0, cnt1 SHALL exist; cntj increments by 1 on each output-j transfer, saturating at 0xFFFF.
REQ-027 cnt_clr=1 SHALL set both counters to 0 next cycle, overriding a simultaneous increment.
REQ-028 When DEMUX_CNT_EN is undefined, cnt_clr/cnt0/cnt1 and counter logic SHALL be absent; all other behaviour identical.

Verification
REQ-029 Reset then in_valid=1, in_sel=0, in_data=0x12345678, out0_ready=1 -> next cycle out0_valid=1, out0_data=0x12345678, out1_valid=0.
REQ-030 out1_ready=0, send 0xA to port 1 then 0xB to port 1 -> 0xA held on out1_data, in_ready=0 for second word; raise out1_ready -> 0xA transfers, 0xB appears next cycle.
REQ-031 Port 1 stalled with word held, send 0xC to port 0 -> accepted, out0_data=0xC next cycle, out1_data unchanged.
REQ-032 Both ready=1, alternate in_sel every cycle for 8 words -> in_ready=1 throughout, each word on its port exactly one cycle later, order preserved per port.
REQ-033 Words held on both ports, pulse rst_n=0 between edges -> both valids and data 0 immediately; no transfer after release.
REQ-034 DEMUX_CNT_EN defined: 3 transfers on port 0, 1 on port 1 -> cnt0=3, cnt1=1; cnt_clr with concurrent port-0 transfer -> cnt0=0; force cnt0=0xFFFF, transfer -> stays 0xFFFF.
